// File: rtl/fetch_unit_pkg.sv
// Shared widths, NOP encoding and per-cycle action codes for the fetch stage.
package fetch_unit_pkg;
  localparam int          PC_W  = 32;
  localparam int          CNT_W = 16;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef enum logic [2:0] {
    ACT_FETCH,
    ACT_STALL,
    ACT_FLUSH,
    ACT_JUMP,
    ACT_SHADOW
  } fetch_act_e;

  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Control, instruction-memory and IF/ID bundle between the pipeline and the fetch unit.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic             pc_wr;
  logic             if_id_wr;
  logic             flush;
  logic [PC_W-1:0]  br_target;
  logic             jump;
  logic [PC_W-1:0]  jump_target;
  logic [PC_W-1:0]  imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      if_id_ir;
  logic [PC_W-1:0]  if_id_pc4;
  logic             if_id_valid;
  logic             shadow_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output pc_wr, if_id_wr, flush, br_target, jump, jump_target, imem_rdata,
    input  imem_addr, if_id_ir, if_id_pc4, if_id_valid, shadow_busy, stall_cnt, redirect_cnt
  );

  modport slave (
    input  pc_wr, if_id_wr, flush, br_target, jump, jump_target, imem_rdata,
    output imem_addr, if_id_ir, if_id_pc4, if_id_valid, shadow_busy, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/fetch_unit_sat_counter.sv
// Statistics counter: increments when enabled, sticks at all-ones, synchronous clear.
module sat_counter
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID latch, jump-shadow bubbles and stall/redirect stats.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          JUMP_SHADOW = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.slave  bus
);
  localparam logic [1:0] SHADOW_LD = 2'(JUMP_SHADOW);

  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [PC_W-1:0] r_pc4;
  logic            r_valid;
  logic [1:0]      r_shadow;

  fetch_act_e      w_act;
  logic [PC_W-1:0] w_pc_nxt;
  logic [31:0]     w_ir_nxt;
  logic [PC_W-1:0] w_pc4_nxt;
  logic            w_valid_nxt;
  logic [1:0]      w_shadow_nxt;
  logic            w_stall_inc;
  logic            w_redir_inc;

  // Priority among redirect, shadow drain and stall; rst is applied in the register block.
  always_comb begin
    w_act = ACT_FETCH;
    if (bus.flush)
      w_act = ACT_FLUSH;
    else if (bus.jump)
      w_act = ACT_JUMP;
    else if (r_shadow != 2'd0)
      w_act = ACT_SHADOW;
    else if (!bus.pc_wr)
      w_act = ACT_STALL;
  end

  always_comb begin
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_pc4_nxt    = r_pc4;
    w_valid_nxt  = r_valid;
    w_shadow_nxt = r_shadow;
    unique case (w_act)
      ACT_FLUSH: begin
        w_pc_nxt     = bus.br_target;
        w_ir_nxt     = NOP;
        w_pc4_nxt    = '0;
        w_valid_nxt  = 1'b0;
        w_shadow_nxt = 2'd0;
      end
      ACT_JUMP: begin
        w_pc_nxt     = bus.jump_target;
        w_ir_nxt     = NOP;
        w_pc4_nxt    = '0;
        w_valid_nxt  = 1'b0;
        w_shadow_nxt = SHADOW_LD;
      end
      ACT_SHADOW: begin
        w_ir_nxt     = NOP;
        w_pc4_nxt    = '0;
        w_valid_nxt  = 1'b0;
        w_shadow_nxt = r_shadow - 2'd1;
      end
      default: begin
        // pc_wr and if_id_wr act independently; a held PC with a written IF/ID re-latches the same word.
        if (bus.pc_wr)
          w_pc_nxt = pc_plus4(r_pc);
        if (bus.if_id_wr) begin
          w_ir_nxt    = bus.imem_rdata;
          w_pc4_nxt   = pc_plus4(r_pc);
          w_valid_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= NOP;
      r_pc4    <= '0;
      r_valid  <= 1'b0;
      r_shadow <= 2'd0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_pc4    <= w_pc4_nxt;
      r_valid  <= w_valid_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  assign w_stall_inc = (w_act == ACT_STALL);
  assign w_redir_inc = (w_act == ACT_FLUSH) || (w_act == ACT_JUMP);

  sat_counter u_stall_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_stall_inc),
    .o_cnt (bus.stall_cnt)
  );

  sat_counter u_redirect_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_redir_inc),
    .o_cnt (bus.redirect_cnt)
  );

  assign bus.imem_addr   = r_pc;
  assign bus.if_id_ir    = r_ir;
  assign bus.if_id_pc4   = r_pc4;
  assign bus.if_id_valid = r_valid;
  assign bus.shadow_busy = (r_shadow != 2'd0);
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts every cycle, DUT is compared after the edge.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          JS     = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] pc4;
    logic        valid;
    logic        busy;
    logic [15:0] stall;
    logic [15:0] redir;
    logic        en;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  fetch_unit_if bus ();

  always #5 clk = ~clk;

  // Word at address A is (A>>2)+10, so addresses 0,4,8 return 0xA,0xB,0xC.
  assign bus.imem_rdata = (bus.imem_addr >> 2) + 32'd10;

  fetch_unit #(.RESET_PC(RST_PC), .JUMP_SHADOW(JS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  logic [31:0] m_pc, m_ir, m_pc4;
  logic        m_valid;
  int          m_sh;
  int          m_stall, m_redir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'd10;
  endfunction

  task automatic model(input logic rs, input logic fl, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic pcw, input logic idw);
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (rs) begin
      m_pc = RST_PC; m_ir = 0; m_pc4 = 0; m_valid = 0; m_sh = 0; m_stall = 0; m_redir = 0;
    end else if (fl || jp) begin
      m_pc    = fl ? bt : jt;
      m_ir    = 0;
      m_valid = 0;
      m_sh    = fl ? 0 : JS;
      if (m_redir < 65535) m_redir++;
    end else if (m_sh > 0) begin
      m_ir    = 0;
      m_valid = 0;
      m_sh--;
    end else begin
      if (!pcw) begin
        if (m_stall < 65535) m_stall++;
      end else
        m_pc = old_pc + 32'd4;
      if (idw) begin
        m_ir    = mem_word(old_pc);
        m_pc4   = old_pc + 32'd4;
        m_valid = 1;
      end
    end
  endtask

  task automatic step(input logic rs, input logic fl, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic pcw, input logic idw,
                      input logic en);
    exp_t e;
    exp_t got;
    rst = rs; bus.flush = fl; bus.br_target = bt; bus.jump = jp; bus.jump_target = jt;
    bus.pc_wr = pcw; bus.if_id_wr = idw;
    model(rs, fl, bt, jp, jt, pcw, idw);
    e.pc = m_pc; e.ir = m_ir; e.pc4 = m_pc4; e.valid = m_valid; e.busy = (m_sh != 0);
    e.stall = 16'(m_stall); e.redir = 16'(m_redir); e.en = en;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    if (got.en) begin
      check("pc", bus.imem_addr, got.pc);
      check("ir", bus.if_id_ir, got.ir);
      check("valid", 32'(bus.if_id_valid), 32'(got.valid));
      if (got.valid) check("pc4", bus.if_id_pc4, got.pc4);
      check("busy", 32'(bus.shadow_busy), 32'(got.busy));
      check("stall_cnt", 32'(bus.stall_cnt), 32'(got.stall));
      check("redir_cnt", 32'(bus.redirect_cnt), 32'(got.redir));
    end
  endtask

  task automatic norm();
    step(0, 0, 0, 0, 0, 1, 1, 1);
  endtask

  initial begin
    m_pc = 0; m_ir = 0; m_pc4 = 0; m_valid = 0; m_sh = 0; m_stall = 0; m_redir = 0;
    rst = 1; bus.flush = 0; bus.br_target = 0; bus.jump = 0; bus.jump_target = 0;
    bus.pc_wr = 1; bus.if_id_wr = 1;

    step(1, 0, 0, 0, 0, 1, 1, 1);
    step(1, 1, 32'h40, 1, 32'h80, 0, 0, 1);
    check("rst_pc", bus.imem_addr, 32'h0);
    check("rst_valid", 32'(bus.if_id_valid), 32'h0);

    // Three normal fetches of 0xA, 0xB, 0xC.
    norm(); check("f1_ir", bus.if_id_ir, 32'hA); check("f1_pc4", bus.if_id_pc4, 32'h4);
    norm(); check("f2_ir", bus.if_id_ir, 32'hB); check("f2_pc4", bus.if_id_pc4, 32'h8);
    norm(); check("f3_ir", bus.if_id_ir, 32'hC); check("f3_pc4", bus.if_id_pc4, 32'hC);
    check("f3_addr", bus.imem_addr, 32'hC);
    norm();

    // Full stall at 0x10 for two cycles.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("stall_pc", bus.imem_addr, 32'h10);
    check("stall_n", 32'(bus.stall_cnt), 32'd2);
    check("stall_ir", bus.if_id_ir, 32'hD);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("reload_ir", bus.if_id_ir, 32'h0000_000E);

    // flush wins over jump.
    step(0, 1, 32'h40, 1, 32'h80, 0, 0, 1);
    check("fj_pc", bus.imem_addr, 32'h40);
    check("fj_busy", 32'(bus.shadow_busy), 32'h0);
    check("fj_redir", 32'(bus.redirect_cnt), 32'd1);
    norm();

    // Jump with two shadow bubbles, fetch of 0x80 on the 4th cycle.
    step(0, 0, 0, 1, 32'h80, 1, 1, 1);
    norm(); check("sh1_busy", 32'(bus.shadow_busy), 32'h1); check("sh1_pc", bus.imem_addr, 32'h80);
    norm(); check("sh2_pc", bus.imem_addr, 32'h80); check("sh2_valid", 32'(bus.if_id_valid), 32'h0);
    norm(); check("sh_fetch_ir", bus.if_id_ir, 32'h0000_002A); check("sh_fetch_pc", bus.imem_addr, 32'h84);

    // Jump during shadow re-arms it; stalls during shadow do not count.
    step(0, 0, 0, 1, 32'h100, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 32'h200, 1, 1, 1);
    norm(); norm(); norm();

    // Reset mid-shadow.
    step(0, 0, 0, 1, 32'h300, 1, 1, 1);
    step(1, 0, 0, 0, 0, 1, 1, 1);
    check("rmid_busy", 32'(bus.shadow_busy), 32'h0);
    check("rmid_redir", 32'(bus.redirect_cnt), 32'h0);

    // PC wrap and unaligned target.
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 1, 1, 1);
    norm(); check("wrap_pc", bus.imem_addr, 32'h0); check("wrap_pc4", bus.if_id_pc4, 32'h0);
    step(0, 1, 32'h13, 0, 0, 1, 1, 1);
    norm(); check("unal_pc", bus.imem_addr, 32'h17);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), $urandom,
           ($urandom_range(0, 9) == 0), $urandom,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 1);
    end

    // Drive stall_cnt up to saturation.
    step(1, 0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 65533; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("sat_pre", 32'(bus.stall_cnt), 32'h0000_FFFE);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    check("sat_hold", 32'(bus.stall_cnt), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
